alu_share_arbiter: RTL and testbench

Shares the single combinational ALU between two requesters: port 0, the main execute stage, and port 1, the branch/address helper. It round-robin arbitrates valid/ready requests and registers the winning operands and control code onto the ALU inputs. It then captures the result and zero flag and returns them on the winner's response channel with valid/ready backpressure. It sits between the requesters and the ALU instance and is the only driver of the ALU inputs.

---
 rtl/alu_share_arbiter.sv | 104 ++++++++++
 tb/tb_alu_share_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Two-port round-robin arbiter in front of a shared combinational ALU.
// Registers the winner's operands, captures the ALU result and returns it with valid/ready.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_op1,
  input  logic [DATA_W-1:0] req0_op2,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_op1,
  input  logic [DATA_W-1:0] req1_op2,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic [DATA_W-1:0] alu_op1_o,
  output logic [DATA_W-1:0] alu_op2_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state, state_next;
  logic   owner;
  logic   prio;
  logic   grant;
  logic   accept;
  logic   done;

  // Grant goes to the lone valid port, or to prio when both are valid.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    accept     = 1'b0;
    done       = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state)
      IDLE: begin
        grant      = (req0_valid && req1_valid) ? prio : req1_valid;
        accept     = req0_valid || req1_valid;
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
        if (accept) state_next = EXEC;
      end
      EXEC: state_next = RESP;
      RESP: begin
        rsp0_valid = !owner;
        rsp1_valid = owner;
        done       = owner ? rsp1_ready : rsp0_ready;
        if (done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      prio       <= 1'b0;
      alu_op1_o  <= '0;
      alu_op2_o  <= '0;
      alu_ctrl_o <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        owner      <= grant;
        alu_op1_o  <= grant ? req1_op1  : req0_op1;
        alu_op2_o  <= grant ? req1_op2  : req0_op2;
        alu_ctrl_o <= grant ? req1_ctrl : req0_ctrl;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result_i;
        rsp_zero   <= alu_zero_i;
      end
      // Last served port drops to lowest priority.
      if (done) prio <= ~owner;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vector table, multi-cycle corner sequences,
// and random traffic checked against a transaction-level reference model.
module tb_alu_share_arbiter;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [CW-1:0] req0_ctrl, req1_ctrl;
  logic          rsp0_valid, rsp1_valid;
  logic          rsp0_ready, rsp1_ready;
  logic [DW-1:0] rsp_result;
  logic          rsp_zero;
  logic [DW-1:0] alu_op1, alu_op2, alu_result;
  logic [CW-1:0] alu_ctrl;
  logic          alu_zero;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_share_arbiter #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_ctrl(req1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_op1_o(alu_op1), .alu_op2_o(alu_op2), .alu_ctrl_o(alu_ctrl),
    .alu_result_i(alu_result), .alu_zero_i(alu_zero),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [CW-1:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_op1, alu_op2, alu_ctrl);
  assign alu_zero   = (alu_result == '0);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op1 = '0; req0_op2 = '0; req0_ctrl = '0;
    req1_op1 = '0; req1_op2 = '0; req1_ctrl = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic          port;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] exp_res;
    logic          exp_zero;
  } vec_t;

  // One complete operation on an otherwise quiet bus; operands are zeroed after accept.
  task automatic run_op(input vec_t v, input int unsigned idx);
    @(negedge clk);
    clear_inputs();
    if (v.port) begin
      req1_valid = 1'b1; req1_op1 = v.op1; req1_op2 = v.op2; req1_ctrl = v.ctrl;
    end else begin
      req0_valid = 1'b1; req0_op1 = v.op1; req0_op2 = v.op2; req0_ctrl = v.ctrl;
    end
    #1;
    check($sformatf("v%0d ready", idx), 64'({req0_ready, req1_ready, busy}),
          64'({!v.port, v.port, 1'b0}));
    @(negedge clk);
    clear_inputs();
    #1;
    check($sformatf("v%0d alu_op1", idx), 64'(alu_op1), 64'(v.op1));
    check($sformatf("v%0d alu_op2", idx), 64'(alu_op2), 64'(v.op2));
    check($sformatf("v%0d alu_ctrl", idx), 64'(alu_ctrl), 64'(v.ctrl));
    check($sformatf("v%0d exec flags", idx), 64'({rsp0_valid, rsp1_valid, busy}), 64'(3'b001));
    @(negedge clk);
    #1;
    check($sformatf("v%0d rsp_valid", idx), 64'({rsp0_valid, rsp1_valid}),
          64'({!v.port, v.port}));
    check($sformatf("v%0d result", idx), 64'(rsp_result), 64'(v.exp_res));
    check($sformatf("v%0d zero", idx), 64'(rsp_zero), 64'(v.exp_zero));
    @(negedge clk);
    #1;
    check($sformatf("v%0d idle", idx), 64'({rsp0_valid, rsp1_valid, busy}), 64'(3'b000));
  endtask

  // Reference model state: one transaction in flight, counted in edges since accept.
  typedef struct {
    logic          port;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [CW-1:0] ctrl;
  } txn_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 32'd5,         32'd7,         4'b0010, 32'd12,        1'b0};
    vecs[1] = '{1'b1, 32'd9,         32'd9,         4'b0110, 32'd0,         1'b1};
    vecs[2] = '{1'b0, 32'h0000_00F0, 32'h0000_000F, 4'b0001, 32'h0000_00FF, 1'b0};
    vecs[3] = '{1'b1, 32'd3,         32'd8,         4'b0111, 32'd1,         1'b0};
    vecs[4] = '{1'b0, 32'hFFFF_0000, 32'h1234_5678, 4'b0000, 32'h1234_0000, 1'b0};
    vecs[5] = '{1'b1, 32'd0,         32'd0,         4'b1100, 32'hFFFF_FFFF, 1'b0};
    vecs[6] = '{1'b0, 32'd1,         32'd2,         4'b1111, 32'd0,         1'b1};
    vecs[7] = '{1'b1, 32'hFFFF_FFFF, 32'd1,         4'b0111, 32'd1,         1'b0};
    vecs[8] = '{1'b0, 32'hFFFF_FFFF, 32'd1,         4'b0010, 32'd0,         1'b1};
    vecs[9] = '{1'b1, 32'd8,         32'd3,         4'b0111, 32'd0,         1'b1};

    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    #1;
    check("reset outputs", 64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, rsp_zero}),
          64'(6'b0));
    check("reset alu regs", 64'({alu_op1, alu_ctrl}), 64'(0));
    check("reset result", 64'(rsp_result), 64'(0));
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 10; i++) run_op(vecs[i], i);

    // Fairness: both ports held valid, grants must alternate starting at port 0.
    do_reset();
    for (int unsigned i = 0; i < 6; i++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_op1 = 32'd9;  req0_op2 = 32'd9;  req0_ctrl = 4'b0110;
      req1_valid = 1'b1; req1_op1 = 32'hF0; req1_op2 = 32'h0F; req1_ctrl = 4'b0001;
      #1;
      check($sformatf("rr grant %0d", i), 64'({req0_ready, req1_ready}),
            (i % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
      @(negedge clk);
      @(negedge clk);
      #1;
      check($sformatf("rr rsp %0d", i), 64'({rsp0_valid, rsp1_valid}),
            (i % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
      check($sformatf("rr result %0d", i), 64'({rsp_result, rsp_zero}),
            (i % 2 == 0) ? 64'({32'd0, 1'b1}) : 64'({32'hFF, 1'b0}));
    end
    @(negedge clk);
    clear_inputs();

    // Backpressure on port 1 while port 0 waits.
    @(negedge clk);
    clear_inputs();
    req1_valid = 1'b1; req1_op1 = 32'd3; req1_op2 = 32'd8; req1_ctrl = 4'b0111;
    rsp1_ready = 1'b0;
    #1;
    check("bp accept", 64'({req0_ready, req1_ready}), 64'(2'b01));
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op1 = 32'd1; req0_op2 = 32'd1; req0_ctrl = 4'b0010;
    #1;
    check("bp exec ready", 64'({req0_ready, req1_ready}), 64'(2'b00));
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("bp hold %0d", i),
            64'({req0_ready, rsp0_valid, rsp1_valid, busy, rsp_result, rsp_zero}),
            64'({1'b0, 1'b0, 1'b1, 1'b1, 32'd1, 1'b0}));
    end
    @(negedge clk);
    rsp1_ready = 1'b1;
    #1;
    check("bp release cycle", 64'({rsp1_valid, req0_ready}), 64'(2'b10));
    @(negedge clk);
    #1;
    check("bp done", 64'({rsp1_valid, busy, req0_ready}), 64'(3'b001));
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    check("bp next exec", 64'(alu_op1), 64'(1));
    @(negedge clk);
    #1;
    check("bp next rsp", 64'({rsp0_valid, rsp_result}), 64'({1'b1, 32'd2}));
    @(negedge clk);
    clear_inputs();

    // Reset during EXEC discards the operation.
    @(negedge clk);
    req0_valid = 1'b1; req0_op1 = 32'd4; req0_op2 = 32'd4; req0_ctrl = 4'b0010;
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    #1;
    check("midreset outputs", 64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, rsp_zero}),
          64'(6'b0));
    check("midreset alu", 64'({alu_op1, alu_op2, alu_ctrl}), 64'(0));
    check("midreset result", 64'(rsp_result), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post reset quiet", 64'({rsp0_valid, rsp1_valid, busy}), 64'(3'b000));
    run_op(vecs[5], 100);

    // Random traffic against the reference model.
    do_reset();
    begin
      logic        m_free = 1'b1;
      logic        m_prio = 1'b0;
      int unsigned m_age  = 0;
      txn_t        m_txn  = '{1'b0, '0, '0, '0};
      for (int unsigned cyc = 0; cyc < 600; cyc++) begin
        logic          w;
        logic          e_r0, e_r1, e_v0, e_v1;
        logic [DW-1:0] e_res;
        @(negedge clk);
        req0_valid = ($urandom_range(0, 99) < 45);
        req1_valid = ($urandom_range(0, 99) < 45);
        req0_op1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        req0_op2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        req1_op1 = ($urandom_range(0, 3) == 0) ? req1_op2 : $urandom;
        req1_op2 = $urandom;
        req0_ctrl = 4'($urandom_range(0, 15));
        req1_ctrl = 4'($urandom_range(0, 15));
        rsp0_ready = ($urandom_range(0, 99) < 60);
        rsp1_ready = ($urandom_range(0, 99) < 60);
        w    = (req0_valid && req1_valid) ? m_prio : req1_valid;
        e_r0 = m_free && req0_valid && !w;
        e_r1 = m_free && req1_valid && w;
        e_v0 = !m_free && m_age >= 1 && !m_txn.port;
        e_v1 = !m_free && m_age >= 1 && m_txn.port;
        #1;
        check($sformatf("rnd hs %0d", cyc),
              64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy}),
              64'({e_r0, e_r1, e_v0, e_v1, !m_free}));
        if (!m_free && m_age == 0)
          check($sformatf("rnd alu %0d", cyc), 64'({alu_op1, alu_ctrl}),
                64'({m_txn.op1, m_txn.ctrl}));
        if (e_v0 || e_v1) begin
          e_res = alu_ref(m_txn.op1, m_txn.op2, m_txn.ctrl);
          check($sformatf("rnd result %0d", cyc), 64'({rsp_result, rsp_zero}),
                64'({e_res, e_res == '0}));
        end
        if (m_free) begin
          if (req0_valid || req1_valid) begin
            m_txn  = w ? '{1'b1, req1_op1, req1_op2, req1_ctrl}
                       : '{1'b0, req0_op1, req0_op2, req0_ctrl};
            m_free = 1'b0;
            m_age  = 0;
          end
        end else if (m_age >= 1 && (m_txn.port ? rsp1_ready : rsp0_ready)) begin
          m_free = 1'b1;
          m_prio = ~m_txn.port;
        end else begin
          m_age = 1;
        end
      end
    end

    @(negedge clk);
    clear_inputs();
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
